// File: rtl/oldest2_pkg.sv
// Shared types and default sizing for the oldest-first request tracker.
// The entry struct and pointer type are sized from the defaults below.
package oldest2_pkg;

  localparam int DEF_SEL_WIDTH      = 16;
  localparam int DEF_PRIORITY_WIDTH = 4;
  localparam int DEF_TAG_WIDTH      = 8;

  // The circular index only wraps cleanly when the entry count is a power of two.
  localparam bit SEL_WIDTH_OK = (DEF_SEL_WIDTH == (1 << DEF_PRIORITY_WIDTH));

  // The MSB is the wrap bit; it separates full (span == SEL_WIDTH) from empty (span == 0).
  typedef logic [DEF_PRIORITY_WIDTH:0] ptr_t;

  typedef struct packed {
    logic                     valid;
    logic                     rdy;
    logic [DEF_TAG_WIDTH-1:0] tag;
  } entry_t;

endpackage

// File: rtl/oldest2_head_retire.sv
// Head retire step: skips up to two freed entries at the head of the window.
// It looks only at registered valid bits, so it never depends on the current cycle's grants.
module oldest2_head_retire
  import oldest2_pkg::*;
#(
  parameter int SEL_WIDTH      = DEF_SEL_WIDTH,
  parameter int PRIORITY_WIDTH = DEF_PRIORITY_WIDTH
) (
  input  logic [PRIORITY_WIDTH-1:0] head_idx,
  input  logic [PRIORITY_WIDTH:0]   span,
  input  logic [SEL_WIDTH-1:0]      valid,
  output logic [1:0]                head_inc
);

  localparam logic [PRIORITY_WIDTH-1:0] IDX_ONE  = (PRIORITY_WIDTH)'(1);
  localparam logic [PRIORITY_WIDTH:0]   SPAN_TWO = (PRIORITY_WIDTH + 1)'(2);

  logic [PRIORITY_WIDTH-1:0] next_idx;

  assign next_idx = head_idx + IDX_ONE;

  // The second step is only taken when the first one is, so retirement stays in order.
  always_comb begin
    head_inc = 2'd0;
    if ((span != '0) && !valid[head_idx]) begin
      head_inc = 2'd1;
      if ((span >= SPAN_TWO) && !valid[next_idx]) begin
        head_inc = 2'd2;
      end
    end
  end

endmodule

// File: rtl/oldest2_req_tracker.sv
// Circular request tracker feeding the 2-grant oldest-first arbiter: allocates in order,
// presents ready entries as requests, frees granted entries and retires the head past them.
module oldest2_req_tracker
  import oldest2_pkg::*;
#(
  parameter int SEL_WIDTH      = DEF_SEL_WIDTH,
  parameter int PRIORITY_WIDTH = DEF_PRIORITY_WIDTH,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      alloc0_valid_i,
  input  logic                      alloc1_valid_i,
  input  logic [TAG_WIDTH-1:0]      alloc0_tag_i,
  input  logic [TAG_WIDTH-1:0]      alloc1_tag_i,
  output logic                      alloc_ready_o,
  output logic [PRIORITY_WIDTH-1:0] alloc0_idx_o,
  output logic [PRIORITY_WIDTH-1:0] alloc1_idx_o,
  input  logic                      wake_valid_i,
  input  logic [PRIORITY_WIDTH-1:0] wake_idx_i,
  input  logic                      issue_en0_i,
  input  logic                      issue_en1_i,
  output logic [SEL_WIDTH-1:0]      req_o,
  output logic [PRIORITY_WIDTH-1:0] priority_fix_o,
  output logic                      new_req_first_o,
  output logic                      new_req_second_o,
  input  logic                      first_grant_valid_i,
  input  logic [PRIORITY_WIDTH-1:0] first_grant_index_i,
  input  logic                      second_grant_valid_i,
  input  logic [PRIORITY_WIDTH-1:0] second_grant_index_i,
  output logic                      issue0_valid_o,
  output logic [TAG_WIDTH-1:0]      issue0_tag_o,
  output logic                      issue1_valid_o,
  output logic [TAG_WIDTH-1:0]      issue1_tag_o
);

  typedef logic [PRIORITY_WIDTH-1:0] idx_t;

  localparam ptr_t PTR_ONE        = ptr_t'(1);
  localparam ptr_t PTR_TWO        = ptr_t'(2);
  localparam ptr_t SPAN_ALLOC_MAX = ptr_t'(SEL_WIDTH - 2);
  localparam idx_t IDX_ONE        = idx_t'(1);

  entry_t entries [SEL_WIDTH];

  ptr_t                 head;
  ptr_t                 tail;
  ptr_t                 span;
  ptr_t                 tail_step;
  logic [1:0]           head_inc;
  logic [SEL_WIDTH-1:0] valid_vec;
  logic [SEL_WIDTH-1:0] rdy_vec;
  logic [SEL_WIDTH-1:0] valid_nxt;
  logic [SEL_WIDTH-1:0] rdy_nxt;
  logic                 accept0;
  logic                 accept1;
  logic                 grant0;
  logic                 grant1;

  always_comb begin
    for (int i = 0; i < SEL_WIDTH; i++) begin
      valid_vec[i] = entries[i].valid;
      rdy_vec[i]   = entries[i].rdy;
    end
  end

  assign span             = tail - head;
  assign alloc_ready_o    = rst_n & (span <= SPAN_ALLOC_MAX);
  assign alloc0_idx_o     = tail[PRIORITY_WIDTH-1:0];
  assign alloc1_idx_o     = tail[PRIORITY_WIDTH-1:0] + IDX_ONE;
  assign priority_fix_o   = head[PRIORITY_WIDTH-1:0];
  assign req_o            = valid_vec & rdy_vec;
  assign new_req_first_o  = issue_en0_i;
  assign new_req_second_o = issue_en1_i;

  // alloc1 alone is illegal and dropped; a slot-1 alloc always rides on slot 0.
  assign accept0   = alloc0_valid_i & alloc_ready_o;
  assign accept1   = accept0 & alloc1_valid_i;
  assign tail_step = accept1 ? PTR_TWO : (accept0 ? PTR_ONE : '0);

  // Grants are qualified by the registered request; a duplicate second grant is dropped.
  assign grant0 = first_grant_valid_i & req_o[first_grant_index_i];
  assign grant1 = second_grant_valid_i & req_o[second_grant_index_i]
                & ~(first_grant_valid_i & (first_grant_index_i == second_grant_index_i));

  // Order matters: grant overrides wake on the same entry.
  always_comb begin
    valid_nxt = valid_vec;
    rdy_nxt   = rdy_vec;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (wake_valid_i && (wake_idx_i == idx_t'(i)) && valid_vec[i]) begin
        rdy_nxt[i] = 1'b1;
      end
      if ((grant0 && (first_grant_index_i == idx_t'(i))) ||
          (grant1 && (second_grant_index_i == idx_t'(i)))) begin
        valid_nxt[i] = 1'b0;
        rdy_nxt[i]   = 1'b0;
      end
      if ((accept0 && (alloc0_idx_o == idx_t'(i))) ||
          (accept1 && (alloc1_idx_o == idx_t'(i)))) begin
        valid_nxt[i] = 1'b1;
        rdy_nxt[i]   = 1'b0;
      end
    end
  end

  oldest2_head_retire #(
    .SEL_WIDTH      (SEL_WIDTH),
    .PRIORITY_WIDTH (PRIORITY_WIDTH)
  ) u_head_retire (
    .head_idx (head[PRIORITY_WIDTH-1:0]),
    .span     (span),
    .valid    (valid_vec),
    .head_inc (head_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      issue0_valid_o <= 1'b0;
      issue0_tag_o   <= '0;
      issue1_valid_o <= 1'b0;
      issue1_tag_o   <= '0;
      for (int i = 0; i < SEL_WIDTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush_i) begin
      // Tags are left in place; only the bookkeeping is cleared.
      head           <= '0;
      tail           <= '0;
      issue0_valid_o <= 1'b0;
      issue1_valid_o <= 1'b0;
      for (int i = 0; i < SEL_WIDTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].rdy   <= 1'b0;
      end
    end else begin
      head <= head + ptr_t'(head_inc);
      tail <= tail + tail_step;
      for (int i = 0; i < SEL_WIDTH; i++) begin
        entries[i].valid <= valid_nxt[i];
        entries[i].rdy   <= rdy_nxt[i];
      end
      if (accept0) entries[alloc0_idx_o].tag <= alloc0_tag_i;
      if (accept1) entries[alloc1_idx_o].tag <= alloc1_tag_i;
      issue0_valid_o <= grant0;
      issue1_valid_o <= grant1;
      if (grant0) issue0_tag_o <= entries[first_grant_index_i].tag;
      if (grant1) issue1_tag_o <= entries[second_grant_index_i].tag;
    end
  end

  always @(posedge clk) begin
    if (rst_n && !flush_i) begin
      assert (SEL_WIDTH == (1 << PRIORITY_WIDTH));
      assert (TAG_WIDTH == DEF_TAG_WIDTH);
      assert (!(alloc1_valid_i && !alloc0_valid_i));
      assert (!first_grant_valid_i || req_o[first_grant_index_i]);
      assert (!second_grant_valid_i || req_o[second_grant_index_i]);
      assert (!(first_grant_valid_i && second_grant_valid_i &&
                (first_grant_index_i == second_grant_index_i)));
    end
  end

endmodule
